// File: rtl/pn_pkg.sv
// Shared spike-word layout, FSM states and FIFO entry type
// for the PN encoder and the PN controller decode path.
package pn_pkg;

   localparam int PN_ID_W   = 7;
   localparam int SPIKE_BIT = 14;
   localparam int RC_BIT    = 15;
   localparam int ID_A_LSB  = 0;
   localparam int ID_A_MSB  = 6;
   localparam int ID_B_LSB  = 7;
   localparam int ID_B_MSB  = 13;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_HOLD,
      ST_FLUSH
   } pn_state_e;

   typedef struct packed {
      logic               rc;
      logic [PN_ID_W-1:0] id;
   } pn_entry_t;

   function automatic logic [15:0] pn_word(
      input logic               rc,
      input logic [PN_ID_W-1:0] id_b,
      input logic [PN_ID_W-1:0] id_a
   );
      logic [15:0] w;
      w                     = '0;
      w[RC_BIT]             = rc;
      w[SPIKE_BIT]          = 1'b0;
      w[ID_B_MSB:ID_B_LSB]  = id_b;
      w[ID_A_MSB:ID_A_LSB]  = id_a;
      return w;
   endfunction

endpackage

// File: rtl/pn_sync_fifo.sv
// Show-ahead synchronous FIFO; pointers carry an extra MSB
// so full and empty are told apart without a counter.
module pn_sync_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             wr_en;
   logic             rd_en;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                  (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign rd_en = pop && !empty;
   assign wr_en = push && (!full || rd_en);
   assign dout  = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/pn_spike_encoder.sv
// Packs fired-neuron IDs into paired spike address words
// and streams them to the inter-core link.
module pn_spike_encoder
   import pn_pkg::*;
#(
   parameter int DEPTH        = 16,
   parameter int HOLD_TIMEOUT = 8,
   parameter int ID_W         = 7
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            fire_valid,
   output logic            fire_ready,
   input  logic [ID_W-1:0] fire_id,
   input  logic            fire_rc,
   input  logic            ts_end,
   output logic [15:0]     oADDR,
   output logic            oValid,
   input  logic            oReady,
   output logic            flush_done,
   output logic            drop_err
);

   localparam int CW = $clog2(HOLD_TIMEOUT) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_TIMEOUT - 1);
   localparam logic [CW-1:0] CNT_MAX  = '1;

   pn_state_e        state, state_n;
   pn_entry_t        head, in_entry;
   logic             full, empty;
   logic             alive;
   logic             push, pop, load, adv;
   logic [ID_W-1:0]  held_id, held_id_n;
   logic             held_vld, held_vld_n;
   logic [CW-1:0]    cnt, cnt_n;
   logic             flush_pend, flush_pend_n;
   logic             done_n, drop_set;
   logic [15:0]      word_n;

   assign fire_ready = alive && !full;
   assign push       = fire_valid && fire_ready;
   assign in_entry   = {fire_rc, fire_id};
   assign adv        = !oValid || oReady;

   pn_sync_fifo #(
      .DEPTH (DEPTH),
      .WIDTH ($bits(pn_entry_t))
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (in_entry),
      .dout  (head),
      .full  (full),
      .empty (empty)
   );

   always_comb begin
      state_n    = state;
      held_id_n  = held_id;
      held_vld_n = held_vld;
      cnt_n      = cnt;
      pop        = 1'b0;
      load       = 1'b0;
      word_n     = '0;
      done_n     = 1'b0;
      drop_set   = 1'b0;
      if (adv) begin
         unique case (state)
            ST_IDLE: begin
               if (!empty && head.id == '0) begin
                  pop      = 1'b1;
                  drop_set = 1'b1;
               end else if (!empty && head.rc) begin
                  pop    = 1'b1;
                  load   = 1'b1;
                  word_n = pn_word(1'b1, '0, head.id);
               end else if (!empty) begin
                  pop        = 1'b1;
                  held_id_n  = head.id;
                  held_vld_n = 1'b1;
                  cnt_n      = '0;
                  state_n    = ST_HOLD;
               end else if (flush_pend) begin
                  state_n = ST_FLUSH;
               end
            end
            ST_HOLD: begin
               if (!empty && head.id == '0) begin
                  pop      = 1'b1;
                  drop_set = 1'b1;
               end else if (!empty && head.rc) begin
                  // rich-club head stays queued; the lone ID goes out first
                  load       = 1'b1;
                  word_n     = pn_word(1'b0, '0, held_id);
                  held_vld_n = 1'b0;
                  state_n    = ST_IDLE;
               end else if (!empty) begin
                  pop        = 1'b1;
                  load       = 1'b1;
                  word_n     = pn_word(1'b0, head.id, held_id);
                  held_vld_n = 1'b0;
                  state_n    = ST_IDLE;
               end else if (flush_pend) begin
                  state_n = ST_FLUSH;
               end else if (cnt == CNT_LAST) begin
                  load       = 1'b1;
                  word_n     = pn_word(1'b0, '0, held_id);
                  held_vld_n = 1'b0;
                  state_n    = ST_IDLE;
               end else if (cnt != CNT_MAX) begin
                  cnt_n = cnt + 1'b1;
               end
            end
            ST_FLUSH: begin
               if (held_vld) begin
                  load       = 1'b1;
                  word_n     = pn_word(1'b0, '0, held_id);
                  held_vld_n = 1'b0;
               end else begin
                  done_n  = 1'b1;
                  state_n = ST_IDLE;
               end
            end
            default: state_n = ST_IDLE;
         endcase
      end
      flush_pend_n = flush_pend;
      if (done_n) flush_pend_n = 1'b0;
      else if (ts_end && state != ST_FLUSH) flush_pend_n = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         held_id    <= '0;
         held_vld   <= 1'b0;
         cnt        <= '0;
         flush_pend <= 1'b0;
         flush_done <= 1'b0;
         drop_err   <= 1'b0;
         alive      <= 1'b0;
         oValid     <= 1'b0;
         oADDR      <= '0;
      end else begin
         state      <= state_n;
         held_id    <= held_id_n;
         held_vld   <= held_vld_n;
         cnt        <= cnt_n;
         flush_pend <= flush_pend_n;
         flush_done <= done_n;
         drop_err   <= drop_err | drop_set;
         alive      <= 1'b1;
         if (load) begin
            oADDR  <= word_n;
            oValid <= 1'b1;
         end else if (oReady) begin
            oValid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_pn_spike_encoder.sv
// Directed bench for pn_spike_encoder: pairing, timeout,
// rich-club ordering, backpressure, drop, flush and reset.
module tb_pn_spike_encoder;

   logic        clk = 1'b0;
   logic        rst;
   logic        fire_valid;
   logic        fire_ready;
   logic [6:0]  fire_id;
   logic        fire_rc;
   logic        ts_end;
   logic [15:0] oADDR;
   logic        oValid;
   logic        oReady;
   logic        flush_done;
   logic        drop_err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pn_spike_encoder dut (
      .clk        (clk),
      .rst        (rst),
      .fire_valid (fire_valid),
      .fire_ready (fire_ready),
      .fire_id    (fire_id),
      .fire_rc    (fire_rc),
      .ts_end     (ts_end),
      .oADDR      (oADDR),
      .oValid     (oValid),
      .oReady     (oReady),
      .flush_done (flush_done),
      .drop_err   (drop_err)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // waits (bounded) for a word, samples it, then spends one cycle
   task automatic get_word(output logic [15:0] w, output int n,
                           output bit ok);
      n = 0;
      while (!oValid && n < 40) begin
         tick();
         n++;
      end
      ok = oValid;
      w  = oADDR;
      tick();
   endtask

   function automatic logic [15:0] pair(input int a, input int b);
      return 16'((b << 7) | a);
   endfunction

   initial begin
      logic [15:0] w;
      int          n;
      bit          ok;
      int          pushed;
      bit          seen;

      rst = 1'b1; fire_valid = 1'b0; fire_id = '0; fire_rc = 1'b0;
      ts_end = 1'b0; oReady = 1'b0;
      tick(); tick(); tick();
      chk("rst_ovalid", oValid, 0);
      chk("rst_oaddr", oADDR, 0);
      chk("rst_ready", fire_ready, 0);
      chk("rst_done", flush_done, 0);
      chk("rst_drop", drop_err, 0);
      rst = 1'b0;
      tick();
      chk("ready_up", fire_ready, 1);

      // pair 5 then 9
      oReady = 1'b1;
      fire_valid = 1'b1; fire_id = 7'd5;
      tick();
      fire_id = 7'd9;
      tick();
      fire_valid = 1'b0;
      chk("pair_early", oValid, 0);
      tick();
      chk("pair_valid", oValid, 1);
      chk("pair_word", oADDR, 16'h0485);
      tick();
      chk("pair_gone", oValid, 0);

      // lone ID timeout
      fire_valid = 1'b1; fire_id = 7'd12;
      tick();
      fire_valid = 1'b0;
      n = 0;
      while (!oValid && n < 20) begin
         tick();
         n++;
      end
      chk("to_latency", n, 9);
      chk("to_word", oADDR, 16'h000C);
      tick();
      chk("to_gone", oValid, 0);

      // rich-club ordering
      fire_valid = 1'b1; fire_id = 7'd3; fire_rc = 1'b0;
      tick();
      fire_id = 7'd40; fire_rc = 1'b1;
      tick();
      fire_id = 7'd7; fire_rc = 1'b0;
      tick();
      fire_valid = 1'b0;
      get_word(w, n, ok);
      chk("rc_ok0", ok, 1);
      chk("rc_w0", w, 16'h0003);
      get_word(w, n, ok);
      chk("rc_ok1", ok, 1);
      chk("rc_w1", w, 16'h8028);
      get_word(w, n, ok);
      chk("rc_ok2", ok, 1);
      chk("rc_w2", w, 16'h0007);

      // backpressure: held reg and output reg absorb two IDs
      oReady = 1'b0;
      pushed = 0;
      fire_valid = 1'b1; fire_id = 7'd1;
      for (int c = 0; c < 25; c++) begin
         if (fire_ready) begin
            tick();
            pushed++;
            fire_id = 7'(pushed + 1);
         end else begin
            tick();
         end
      end
      fire_valid = 1'b0;
      chk("bp_pushed", pushed, 18);
      chk("bp_ready", fire_ready, 0);
      chk("bp_valid", oValid, 1);
      chk("bp_stable", oADDR, 16'h0101);
      oReady = 1'b1;
      for (int k = 0; k < 9; k++) begin
         get_word(w, n, ok);
         chk("bp_ok", ok, 1);
         chk("bp_word", w, pair(2 * k + 1, 2 * k + 2));
      end
      seen = 1'b0;
      for (int c = 0; c < 12; c++) begin
         tick();
         if (oValid) seen = 1'b1;
      end
      chk("bp_drained", seen, 0);
      chk("bp_ready_back", fire_ready, 1);

      // ID 0 dropped
      fire_valid = 1'b1; fire_id = 7'd0;
      tick();
      fire_valid = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 12; c++) begin
         tick();
         if (oValid) seen = 1'b1;
      end
      chk("drop_noword", seen, 0);
      chk("drop_err", drop_err, 1);

      // flush of a held ID
      fire_valid = 1'b1; fire_id = 7'd21;
      tick();
      fire_valid = 1'b0; ts_end = 1'b1;
      tick();
      ts_end = 1'b0;
      get_word(w, n, ok);
      chk("fl_ok", ok, 1);
      chk("fl_lat", n, 2);
      chk("fl_word", w, 16'h0015);
      chk("fl_done", flush_done, 1);
      tick();
      chk("fl_done_off", flush_done, 0);

      // flush with nothing buffered; ts_end during FLUSH ignored
      ts_end = 1'b1;
      tick();
      ts_end = 1'b0;
      chk("fe_d1", flush_done, 0);
      tick();
      chk("fe_d2", flush_done, 0);
      ts_end = 1'b1;
      tick();
      ts_end = 1'b0;
      chk("fe_pulse", flush_done, 1);
      n = 0;
      for (int c = 0; c < 6; c++) begin
         tick();
         if (flush_done) n++;
      end
      chk("fe_single", n, 0);
      chk("drop_sticky", drop_err, 1);

      // reset while a word is pending
      oReady = 1'b0;
      fire_valid = 1'b1; fire_id = 7'd30;
      tick();
      fire_id = 7'd31;
      tick();
      fire_valid = 1'b0;
      tick();
      chk("mr_valid", oValid, 1);
      chk("mr_word", oADDR, 16'h0F9E);
      rst = 1'b1;
      tick();
      chk("mr_ovalid", oValid, 0);
      chk("mr_oaddr", oADDR, 0);
      chk("mr_ready", fire_ready, 0);
      chk("mr_drop", drop_err, 0);
      chk("mr_done", flush_done, 0);
      rst = 1'b0;
      oReady = 1'b1;
      tick();
      chk("mr_ready_up", fire_ready, 1);
      seen = 1'b0;
      for (int c = 0; c < 12; c++) begin
         tick();
         if (oValid) seen = 1'b1;
      end
      chk("mr_abandon", seen, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
